// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: instruction layout, opcodes, funct3 codes and
// the memory-stage state encoding.
package riscv_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_REQ         = 2'd1,
    ST_WAIT_RVALID = 2'd2
  } memstage_state_t;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/memstage_lsu_align.sv
// Combinational lane logic: byte enables, store-lane replication,
// load extraction/extension and misalignment detection.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misaligned
);

  logic [31:0] w_shifted;

  // Access size decode; f3[1:0]=11 falls into the word branch
  always_comb begin
    o_be         = 4'b1111;
    o_wdata      = i_store_data;
    o_misaligned = 1'b0;
    case (i_f3[1:0])
      2'b00: begin
        o_be         = 4'b0001 << i_addr_lo;
        o_wdata      = {4{i_store_data[7:0]}};
        o_misaligned = 1'b0;
      end
      2'b01: begin
        o_be         = 4'b0011 << i_addr_lo;
        o_wdata      = {2{i_store_data[15:0]}};
        o_misaligned = i_addr_lo[0];
      end
      default: begin
        o_be         = 4'b1111;
        o_wdata      = i_store_data;
        o_misaligned = (i_addr_lo != 2'b00);
      end
    endcase
  end

  // Load extraction from the addressed lane
  always_comb begin
    w_shifted   = i_rdata >> {i_addr_lo, 3'b000};
    o_load_data = 32'h0000_0000;
    case (i_f3)
      F3_LB:   o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   o_load_data = w_shifted;
      F3_LBU:  o_load_data = {24'h00_0000, w_shifted[7:0]};
      F3_LHU:  o_load_data = {16'h0000, w_shifted[15:0]};
      default: o_load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/memstage.sv
// Memory-access pipeline stage: issues loads/stores on a req/gnt/rvalid bus
// and forwards results (or pass-through data) to writeback with registered outputs.
module memstage
  import riscv_pkg::*;
#(
  parameter int unsigned RVALID_TIMEOUT = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  instruction_t instruction_i,
  input  logic [31:0]  data_i,
  input  logic [31:0]  store_data_i,
  output logic         dmem_req_o,
  output logic         dmem_we_o,
  output logic [3:0]   dmem_be_o,
  output logic [31:0]  dmem_addr_o,
  output logic [31:0]  dmem_wdata_o,
  input  logic         dmem_gnt_i,
  input  logic         dmem_rvalid_i,
  input  logic [31:0]  dmem_rdata_i,
  output logic         valid_o,
  output logic [31:0]  data_o,
  output instruction_t instruction_o,
  output logic         misaligned_o,
  output logic         bus_err_o
);

  localparam int CNT_W = (RVALID_TIMEOUT > 1) ? $clog2(RVALID_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RVALID_TIMEOUT - 1);

  memstage_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  instruction_t     r_instr, w_instr_nxt;
  logic [1:0]       r_addr_lo, w_addr_lo_nxt;
  logic             r_req, w_req_nxt;
  logic             r_we, w_we_nxt;
  logic [3:0]       r_be, w_be_nxt;
  logic [31:0]      r_addr, w_addr_nxt;
  logic [31:0]      r_wdata, w_wdata_nxt;
  logic             r_valid, w_valid_nxt;
  logic [31:0]      r_data, w_data_nxt;
  instruction_t     r_instr_o, w_instr_o_nxt;
  logic             r_mis, w_mis_nxt;
  logic             r_err, w_err_nxt;

  logic [2:0]  w_f3;
  logic [1:0]  w_addr_lo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;
  logic        w_misaligned;

  // Lane logic looks at the incoming op while idle, the latched op otherwise
  assign w_f3      = (r_state == ST_IDLE) ? instruction_i.funct3 : r_instr.funct3;
  assign w_addr_lo = (r_state == ST_IDLE) ? data_i[1:0] : r_addr_lo;

  lsu_align u_lsu_align (
    .i_f3         (w_f3),
    .i_addr_lo    (w_addr_lo),
    .i_store_data (store_data_i),
    .i_rdata      (dmem_rdata_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data),
    .o_misaligned (w_misaligned)
  );

  // Next-state and next-output logic; result flags default to a single-cycle pulse
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_instr_nxt   = r_instr;
    w_addr_lo_nxt = r_addr_lo;
    w_req_nxt     = r_req;
    w_we_nxt      = r_we;
    w_be_nxt      = r_be;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_valid_nxt   = 1'b0;
    w_mis_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    w_data_nxt    = r_data;
    w_instr_o_nxt = r_instr_o;
    case (r_state)
      ST_IDLE: begin
        if (!valid_i) begin
          w_state_nxt = ST_IDLE;
        end else if (!is_mem_op(instruction_i.opcode)) begin
          w_valid_nxt   = 1'b1;
          w_data_nxt    = data_i;
          w_instr_o_nxt = instruction_i;
        end else if (w_misaligned) begin
          w_valid_nxt   = 1'b1;
          w_mis_nxt     = 1'b1;
          w_data_nxt    = 32'h0000_0000;
          w_instr_o_nxt = instruction_i;
        end else begin
          w_instr_nxt   = instruction_i;
          w_addr_lo_nxt = data_i[1:0];
          w_req_nxt     = 1'b1;
          w_we_nxt      = (instruction_i.opcode == OP_STORE);
          w_be_nxt      = w_be;
          w_addr_nxt    = {data_i[31:2], 2'b00};
          w_wdata_nxt   = (instruction_i.opcode == OP_STORE) ? w_wdata : 32'h0000_0000;
          w_state_nxt   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dmem_gnt_i) begin
          w_req_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_WAIT_RVALID;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT_RVALID: begin
        if (dmem_rvalid_i) begin
          w_valid_nxt   = 1'b1;
          w_data_nxt    = (r_instr.opcode == OP_LOAD) ? w_load_data : 32'h0000_0000;
          w_instr_o_nxt = r_instr;
          w_state_nxt   = ST_IDLE;
        end else if ((RVALID_TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_valid_nxt   = 1'b1;
          w_err_nxt     = 1'b1;
          w_data_nxt    = 32'h0000_0000;
          w_instr_o_nxt = r_instr;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // State, bus and result registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_instr   <= '0;
      r_addr_lo <= 2'b00;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= 4'b0000;
      r_addr    <= 32'h0000_0000;
      r_wdata   <= 32'h0000_0000;
      r_valid   <= 1'b0;
      r_data    <= 32'h0000_0000;
      r_instr_o <= '0;
      r_mis     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_instr   <= w_instr_nxt;
      r_addr_lo <= w_addr_lo_nxt;
      r_req     <= w_req_nxt;
      r_we      <= w_we_nxt;
      r_be      <= w_be_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_valid   <= w_valid_nxt;
      r_data    <= w_data_nxt;
      r_instr_o <= w_instr_o_nxt;
      r_mis     <= w_mis_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign ready_o       = (r_state == ST_IDLE);
  assign dmem_req_o    = r_req;
  assign dmem_we_o     = r_we;
  assign dmem_be_o     = r_be;
  assign dmem_addr_o   = r_addr;
  assign dmem_wdata_o  = r_wdata;
  assign valid_o       = r_valid;
  assign data_o        = r_data;
  assign instruction_o = r_instr_o;
  assign misaligned_o  = r_mis;
  assign bus_err_o     = r_err;

endmodule

// File: tb/tb_memstage.sv
// Self-checking bench for memstage: directed scenarios plus randomized ops
// against an arithmetic reference model.
module tb_memstage;
  import riscv_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  instruction_t instruction_i = '0;
  logic [31:0]  data_i = 32'h0;
  logic [31:0]  store_data_i = 32'h0;
  logic         dmem_req_o, dmem_we_o;
  logic [3:0]   dmem_be_o;
  logic [31:0]  dmem_addr_o, dmem_wdata_o;
  logic         dmem_gnt_i = 1'b0;
  logic         dmem_rvalid_i = 1'b0;
  logic [31:0]  dmem_rdata_i = 32'h0;
  logic         valid_o;
  logic [31:0]  data_o;
  instruction_t instruction_o;
  logic         misaligned_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  memstage #(.RVALID_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .instruction_i(instruction_i), .data_i(data_i), .store_data_i(store_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o),
    .data_o(data_o), .instruction_o(instruction_o), .misaligned_o(misaligned_o),
    .bus_err_o(bus_err_o)
  );

  // observations from the last run_op
  logic         o_got, o_req_seen, o_we, o_mis, o_err, o_pulse2, o_ready_after;
  logic         o_ready_bad, o_unstable;
  int           o_lat, o_req_cycles;
  logic [3:0]   o_be;
  logic [31:0]  o_addr, o_wdata, o_data;
  instruction_t o_instr;

  function automatic instruction_t mk_ins(input logic [6:0] op, input logic [2:0] f3);
    instruction_t t;
    t = instruction_t'($urandom);
    t.opcode = op;
    t.funct3 = f3;
    return t;
  endfunction

  // Reference model: expected bus and result values from size/offset arithmetic
  task automatic model(input instruction_t ins, input logic [31:0] d, sd, rd,
                       output logic e_mem, e_mis, e_we, output logic [3:0] e_be,
                       output logic [31:0] e_addr, e_wdata, e_data);
    int size, off;
    logic [31:0] v;
    e_mem  = (ins.opcode == OP_LOAD) || (ins.opcode == OP_STORE);
    e_we   = (ins.opcode == OP_STORE);
    size   = (ins.funct3[1:0] == 2'b00) ? 1 : (ins.funct3[1:0] == 2'b01) ? 2 : 4;
    off    = int'(d[1:0]);
    e_mis  = e_mem && ((off % size) != 0);
    e_be   = 4'(((1 << size) - 1) << off);
    e_addr = d - 32'(off);
    e_wdata = (size == 1) ? sd[7:0] * 32'h0101_0101 :
              (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    v = rd >> (8 * off);
    case (ins.funct3)
      3'b000:  e_data = (v & 32'hFF) - (((v & 32'h80) != 32'h0) ? 32'd256 : 32'd0);
      3'b001:  e_data = (v & 32'hFFFF) - (((v & 32'h8000) != 32'h0) ? 32'd65536 : 32'd0);
      3'b010:  e_data = v;
      3'b100:  e_data = v & 32'hFF;
      3'b101:  e_data = v & 32'hFFFF;
      default: e_data = 32'h0;
    endcase
    if (!e_mem) e_data = d;
    else if (e_mis || e_we) e_data = 32'h0;
  endtask

  // Issue one instruction and play the bus; gnt after gnt_dly stalls, rvalid
  // rv_dly cycles after the grant (negative: never). Bounded to 60 cycles.
  task automatic run_op(input instruction_t ins, input logic [31:0] d, sd,
                        input int gnt_dly, rv_dly, input logic [31:0] rd);
    int req_n, w;
    logic granted;
    req_n = 0; w = 0; granted = 1'b0;
    o_got = 1'b0; o_req_seen = 1'b0; o_ready_bad = 1'b0; o_unstable = 1'b0; o_lat = -1;
    valid_i = 1'b1; instruction_i = ins; data_i = d; store_data_i = sd;
    @(posedge clk_i); #1;
    valid_i = 1'b0; instruction_i = instruction_t'($urandom);
    data_i = $urandom; store_data_i = $urandom;
    for (int c = 0; c < 60; c++) begin
      if (valid_o) begin
        o_got = 1'b1; o_lat = c; o_data = data_o; o_mis = misaligned_o;
        o_err = bus_err_o; o_instr = instruction_o;
        break;
      end
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
      if (dmem_req_o) begin
        if (!o_req_seen) begin
          o_be = dmem_be_o; o_addr = dmem_addr_o; o_wdata = dmem_wdata_o; o_we = dmem_we_o;
        end else if (o_be !== dmem_be_o || o_addr !== dmem_addr_o ||
                     o_wdata !== dmem_wdata_o || o_we !== dmem_we_o) begin
          o_unstable = 1'b1;
        end
        o_req_seen = 1'b1;
        if (ready_o) o_ready_bad = 1'b1;
        if (req_n == gnt_dly) begin dmem_gnt_i = 1'b1; granted = 1'b1; end
        req_n++;
      end else if (granted) begin
        if (w == rv_dly) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = rd; end
        else dmem_rdata_i = $urandom;
        w++;
      end
      @(posedge clk_i); #1;
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    o_req_cycles = req_n;
    @(posedge clk_i); #1;
    o_pulse2 = valid_o; o_ready_after = ready_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if ({valid_o, misaligned_o, bus_err_o, dmem_req_o, dmem_we_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {valid_o, misaligned_o, bus_err_o, dmem_req_o, dmem_we_o}); end
    checks++; if ({dmem_be_o, dmem_addr_o, dmem_wdata_o, data_o} !== 100'h0) begin
      errors++; $display("FAIL reset_data: be=%h addr=%h wdata=%h data=%h expected all 0", dmem_be_o, dmem_addr_o, dmem_wdata_o, data_o); end
    checks++; if (instruction_o !== 32'h0) begin
      errors++; $display("FAIL reset_instr: got %h expected 0", instruction_o); end
    checks++; if (ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_alu_pass();
    instruction_t ins;
    ins = mk_ins(OP_ALU, 3'b000);
    run_op(ins, 32'h0000_1234, 32'h0, 0, 0, 32'h0);
    checks++; if (!o_got || o_lat != 0) begin
      errors++; $display("FAIL alu_latency: got=%b lat=%0d expected lat 0", o_got, o_lat); end
    checks++; if (o_data !== 32'h0000_1234 || o_instr !== ins) begin
      errors++; $display("FAIL alu_data: got %h/%h expected 00001234/%h", o_data, o_instr, ins); end
    checks++; if (o_req_seen !== 1'b0 || o_pulse2 !== 1'b0) begin
      errors++; $display("FAIL alu_noreq: req=%b pulse2=%b expected 0 0", o_req_seen, o_pulse2); end
  endtask

  task automatic test_lb_sign();
    run_op(mk_ins(OP_LOAD, F3_LB), 32'h0000_0103, 32'h0, 2, 0, 32'h80FF_FFFF);
    checks++; if (o_addr !== 32'h100 || o_be !== 4'b1000 || o_we !== 1'b0) begin
      errors++; $display("FAIL lb_bus: addr=%h be=%b we=%b expected 100 1000 0", o_addr, o_be, o_we); end
    checks++; if (o_req_cycles != 3 || o_unstable) begin
      errors++; $display("FAIL lb_req_hold: cycles=%0d unstable=%b expected 3 0", o_req_cycles, o_unstable); end
    checks++; if (!o_got || o_data !== 32'hFFFF_FF80 || o_lat != 4) begin
      errors++; $display("FAIL lb_data: got %h lat %0d expected ffffff80 lat 4", o_data, o_lat); end
  endtask

  task automatic test_sh_upper();
    run_op(mk_ins(OP_STORE, F3_SH), 32'h0000_0202, 32'hDEAD_BEEF, 0, 1, 32'h1234_5678);
    checks++; if (o_be !== 4'b1100 || o_wdata !== 32'hBEEF_BEEF || o_we !== 1'b1) begin
      errors++; $display("FAIL sh_bus: be=%b wdata=%h we=%b expected 1100 beefbeef 1", o_be, o_wdata, o_we); end
    checks++; if (!o_got || o_data !== 32'h0 || o_mis || o_err) begin
      errors++; $display("FAIL sh_result: got=%b data=%h mis=%b err=%b expected 1 0 0 0", o_got, o_data, o_mis, o_err); end
  endtask

  task automatic test_misaligned();
    run_op(mk_ins(OP_LOAD, F3_LW), 32'h0000_0301, 32'h0, 0, 0, 32'hFFFF_FFFF);
    checks++; if (o_req_seen !== 1'b0) begin
      errors++; $display("FAIL mis_noreq: got req %b expected 0", o_req_seen); end
    checks++; if (!o_got || o_lat != 0 || o_mis !== 1'b1 || o_data !== 32'h0 || o_err !== 1'b0) begin
      errors++; $display("FAIL mis_result: lat=%0d mis=%b data=%h err=%b expected 0 1 0 0", o_lat, o_mis, o_data, o_err); end
  endtask

  task automatic test_timeout();
    run_op(mk_ins(OP_LOAD, F3_LW), 32'h0000_0400, 32'h0, 0, -1, 32'h0);
    checks++; if (!o_got || o_err !== 1'b1 || o_data !== 32'h0 || o_lat != 5) begin
      errors++; $display("FAIL timeout_err: got=%b err=%b data=%h lat=%0d expected 1 1 0 5", o_got, o_err, o_data, o_lat); end
    checks++; if (o_ready_after !== 1'b1 || o_pulse2 !== 1'b0) begin
      errors++; $display("FAIL timeout_ready: ready=%b pulse2=%b expected 1 0", o_ready_after, o_pulse2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int bad;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      v = $urandom;
      valid_i = 1'b1; instruction_i = mk_ins(OP_ALUI, 3'(k)); data_i = v;
      @(posedge clk_i); #1;
      checks++; if (valid_o !== 1'b1 || data_o !== v || ready_o !== 1'b1) begin
        errors++; bad++;
        $display("FAIL b2b_%0d: valid=%b data=%h ready=%b expected 1 %h 1", k, valid_o, data_o, ready_o, v); end
    end
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    checks++; if (valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: valid=%b expected 0", valid_o); end
  endtask

  task automatic test_async_reset();
    int late;
    valid_i = 1'b1; instruction_i = mk_ins(OP_LOAD, F3_LW); data_i = 32'h0000_0800;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    checks++; if (dmem_req_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL areset_req: req=%b ready=%b expected 0 1", dmem_req_o, ready_o); end
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b1; instruction_i = mk_ins(OP_LOAD, F3_LW); data_i = 32'h0000_0900;
    @(posedge clk_i); #1;
    valid_i = 1'b0; dmem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0;
    checks++; if (ready_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      errors++; $display("FAIL areset_wait: ready=%b req=%b expected 0 0", ready_o, dmem_req_o); end
    #2 rst_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      errors++; $display("FAIL areset_clear: ready=%b valid=%b req=%b expected 1 0 0", ready_o, valid_o, dmem_req_o); end
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0;
    late = 0;
    for (int c = 0; c < 4; c++) begin
      if (valid_o) late++;
      @(posedge clk_i); #1;
    end
    checks++; if (late != 0) begin
      errors++; $display("FAIL areset_late_rvalid: valid_o cycles=%0d expected 0", late); end
  endtask

  task automatic test_random();
    instruction_t ins;
    logic [31:0] d, sd, rd, e_addr, e_wdata, e_data;
    logic e_mem, e_mis, e_we;
    logic [3:0] e_be;
    int gd, rv, sel, e_lat;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 4);
      if (sel == 0) ins = mk_ins(OP_ALU, 3'($urandom));
      else if (sel == 1) ins = mk_ins(OP_LUI, 3'($urandom));
      else if (sel == 2) ins = mk_ins(OP_STORE, 3'($urandom_range(0, 3)));
      else ins = mk_ins(OP_LOAD, 3'($urandom));
      d = $urandom; sd = $urandom; rd = $urandom;
      if ($urandom_range(0, 2) == 0) d[1:0] = 2'b00;
      gd = $urandom_range(0, 3); rv = $urandom_range(0, 2);
      model(ins, d, sd, rd, e_mem, e_mis, e_we, e_be, e_addr, e_wdata, e_data);
      run_op(ins, d, sd, gd, rv, rd);
      e_lat = (e_mem && !e_mis) ? gd + rv + 2 : 0;
      checks++; if (!o_got || o_lat != e_lat || o_pulse2 !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_timing: got=%b lat=%0d pulse2=%b expected 1 %0d 0", n, o_got, o_lat, o_pulse2, e_lat); end
      checks++; if (o_data !== e_data || o_mis !== e_mis || o_err !== 1'b0 || o_instr !== ins) begin
        errors++; $display("FAIL rnd%0d_result: data=%h mis=%b err=%b instr=%h expected %h %b 0 %h", n, o_data, o_mis, o_err, o_instr, e_data, e_mis, ins); end
      if (e_mem && !e_mis) begin
        checks++; if (o_be !== e_be || o_addr !== e_addr || o_we !== e_we ||
                      (e_we && o_wdata !== e_wdata) || o_unstable || o_ready_bad || o_req_cycles != gd + 1) begin
          errors++; $display("FAIL rnd%0d_bus: be=%b addr=%h we=%b wdata=%h unst=%b rdy=%b reqc=%0d expected %b %h %b %h 0 0 %0d",
                             n, o_be, o_addr, o_we, o_wdata, o_unstable, o_ready_bad, o_req_cycles, e_be, e_addr, e_we, e_wdata, gd + 1); end
      end else begin
        checks++; if (o_req_seen !== 1'b0) begin
          errors++; $display("FAIL rnd%0d_noreq: req seen %b expected 0", n, o_req_seen); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_lb_sign();
    test_sh_upper();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
